fft_iter_addr_gen: RTL and testbench
====================================

Name: fft_iter_addr_gen

Overview:
- Address generator for the iterative radix-2 in-place FFT datapath.
- Sits downstream of the butterfly control unit and consumes its START/BUT_STROB/ADDR_EN/Wr/LAY_EN/FIRST strobes.
- Tracks the layer and butterfly indices itself and produces data-RAM read/write address pairs plus the twiddle ROM index.
- Flags any disagreement between its own layer tracking and the controller's LAY_EN.

Parameters:
LAYERS, 5, number of FFT stages (log2 N)
BUTTERFLYES, 16, butterflies per layer (N/2 = 2^ButtWL)
LayWL, 3, layer counter width; must hold the value LAYERS
ButtWL, 4, butterfly counter width; address width is ButtWL+1

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous reset, active-high
EN  in  1  global enable; when low, all registers hold
START  in  1  run start pulse, same pulse the controller receives
BUT_STROB  in  1  butterfly operands latched; capture write addresses
ADDR_EN  in  1  butterfly write phase; advance indices
Wr  in  1  write qualifier, sampled with ADDR_EN
LAY_EN  in  1  controller layer-advance indication, used as a check only
FIRST  in  1  controller in layer 0; used as a check only
RD_ADDR_A  out  ButtWL+1  upper butterfly read address
RD_ADDR_B  out  ButtWL+1  lower butterfly read address
TW_ADDR  out  ButtWL  twiddle ROM index
WR_ADDR_A  out  ButtWL+1  upper write address
WR_ADDR_B  out  ButtWL+1  lower write address
WR_EN  out  1  one-cycle RAM write pulse
LAYER_IDX  out  LayWL  current layer
DONE  out  1  all layers written; sticky until START
SYNC_ERR  out  1  sticky strobe/index mismatch

Behaviour:
- Reset (RST=1 at posedge, overrides EN and START): every output and internal register clears to 0, and the FSM goes to IDLE.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN on START.
  - RUN -> FIN on the final write.
  - FIN -> RUN on START. FIN holds otherwise.
  - START in any state: clear layer counter s, butterfly counter b, DONE and SYNC_ERR; go to RUN. START has priority over a simultaneous ADDR_EN.
- Address math, registered one cycle after s or b changes. With h = 2^s, pos = b mod h, grp = b >> s:
  - RD_ADDR_A = grp*2h + pos
  - RD_ADDR_B = RD_ADDR_A + h
  - TW_ADDR = pos << (LAYERS-1-s), truncated to ButtWL bits
  - Input data is already in bit-reversed order; this block does no bit reversal.
- BUT_STROB in RUN: WR_ADDR_A/B <= current RD_ADDR_A/B. WR_ADDR holds otherwise.
- ADDR_EN in RUN:
  - WR_EN <= Wr on the next cycle, as a single-cycle pulse.
  - If b = BUTTERFLYES-1: b wraps to 0 and s increments. Otherwise b increments.
  - If this is the last butterfly of layer LAYERS-1: DONE <= 1, FSM -> FIN, and s stays at LAYERS-1.
- ADDR_EN or BUT_STROB in IDLE or FIN: ignored, no WR_EN.
- Check rules, evaluated with ADDR_EN in RUN. SYNC_ERR is set if either holds:
  - LAY_EN differs from (b = BUTTERFLYES-1 and s != LAYERS-1);
  - FIRST differs from (s = 0).
- SYNC_ERR never changes counting.
- Timing requirement: at least 2 cycles between ADDR_EN and the next BUT_STROB, which is guaranteed by the controller sequence R/DELAY/STROB/WR.
- BUT_STROB and ADDR_EN asserted in the same cycle: capture happens with the pre-advance addresses, then the indices advance.
- EN low mid-run freezes everything; it resumes with no lost strobe unless a strobe arrived while EN was low.
- RST mid-run aborts immediately: all outputs 0, next START required.

Test Plan:
- Reset, then START, wait 2 cycles -> RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0, LAYER_IDX=0, DONE=0.
- Drive 17 BUT_STROB/ADDR_EN pairs with FIRST=1 for the first 16, and LAY_EN on the 16th -> layer 1, b=1: RD_ADDR_A=1, RD_ADDR_B=3, TW_ADDR=8, SYNC_ERR=0.
- Advance to layer 2, b=5 -> RD_ADDR_A=9, RD_ADDR_B=13, TW_ADDR=4; layer 4, b=5 -> RD_ADDR_A=5, RD_ADDR_B=21, TW_ADDR=5.
- Full run of 80 ADDR_EN with Wr=1 -> exactly 80 WR_EN pulses; each WR_ADDR equals the RD_ADDR captured at its BUT_STROB. DONE rises after the 80th; an extra ADDR_EN gives no WR_EN.
- Assert LAY_EN on butterfly 3 of layer 0 -> SYNC_ERR=1 sticky, addresses unaffected; START clears it.
- RST at layer 2 -> all outputs 0 next cycle. START plus simultaneous ADDR_EN -> counters at 0, no advance.

Source files
------------

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 in-place FFT: tracks layer/butterfly
// indices, produces read/write address pairs and twiddle index, and cross-checks the controller.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic              BUT_STROB,
    input  logic              ADDR_EN,
    input  logic              Wr,
    input  logic              LAY_EN,
    input  logic              FIRST,
    output logic [ButtWL:0]   RD_ADDR_A,
    output logic [ButtWL:0]   RD_ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [ButtWL:0]   WR_ADDR_A,
    output logic [ButtWL:0]   WR_ADDR_B,
    output logic              WR_EN,
    output logic [LayWL-1:0]  LAYER_IDX,
    output logic              DONE,
    output logic              SYNC_ERR
);

    localparam int unsigned AW = ButtWL + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [LayWL-1:0]  LAST_LAY = LayWL'(LAYERS - 1);
    localparam logic [ButtWL-1:0] LAST_BUT = ButtWL'(BUTTERFLYES - 1);

    logic [1:0]        state, state_n;
    logic [LayWL-1:0]  s, s_n;
    logic [ButtWL-1:0] b, b_n;
    logic [AW-1:0]     rd_a, rd_b, wr_a, wr_b, wr_a_n, wr_b_n;
    logic [ButtWL-1:0] tw;
    logic              wr_en, wr_en_n;
    logic              done, done_n;
    logic              sync_err, sync_err_n;

    logic [AW-1:0]     span, pos, grp, addr_a, addr_b;
    logic [LayWL-1:0]  tw_sh;
    logic [ButtWL-1:0] tw_idx;
    logic              last_but, last_lay, lay_exp, first_exp;

    // Butterfly address math: span h = 2^s, pos = b mod h, grp = b / h.
    always_comb begin
        span   = AW'(1) << s;
        pos    = AW'(b) & (span - AW'(1));
        grp    = AW'(b) >> s;
        addr_a = ((grp << s) << 1) | pos;
        addr_b = addr_a + span;
        tw_sh  = LAST_LAY - s;
        tw_idx = ButtWL'(pos << tw_sh);
    end

    always_comb begin
        last_but  = (b == LAST_BUT);
        last_lay  = (s == LAST_LAY);
        lay_exp   = last_but && !last_lay;
        first_exp = (s == '0);
    end

    // Next-state and counter/strobe logic; START overrides any same-cycle strobe.
    always_comb begin
        state_n    = state;
        s_n        = s;
        b_n        = b;
        wr_a_n     = wr_a;
        wr_b_n     = wr_b;
        wr_en_n    = 1'b0;
        done_n     = done;
        sync_err_n = sync_err;
        if (START) begin
            state_n    = RUN;
            s_n        = '0;
            b_n        = '0;
            done_n     = 1'b0;
            sync_err_n = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (BUT_STROB) begin
                        wr_a_n = rd_a;
                        wr_b_n = rd_b;
                    end
                    if (ADDR_EN) begin
                        wr_en_n = Wr;
                        if ((LAY_EN != lay_exp) || (FIRST != first_exp)) begin
                            sync_err_n = 1'b1;
                        end
                        if (last_but) begin
                            b_n = '0;
                            if (last_lay) begin
                                done_n  = 1'b1;
                                state_n = FIN;
                            end else begin
                                s_n = s + LayWL'(1);
                            end
                        end else begin
                            b_n = b + ButtWL'(1);
                        end
                    end
                end
                FIN:     state_n = FIN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            s        <= '0;
            b        <= '0;
            rd_a     <= '0;
            rd_b     <= '0;
            tw       <= '0;
            wr_a     <= '0;
            wr_b     <= '0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            sync_err <= 1'b0;
        end else if (EN) begin
            state    <= state_n;
            s        <= s_n;
            b        <= b_n;
            rd_a     <= addr_a;
            rd_b     <= addr_b;
            tw       <= tw_idx;
            wr_a     <= wr_a_n;
            wr_b     <= wr_b_n;
            wr_en    <= wr_en_n;
            done     <= done_n;
            sync_err <= sync_err_n;
        end
    end

    assign RD_ADDR_A = rd_a;
    assign RD_ADDR_B = rd_b;
    assign TW_ADDR   = tw;
    assign WR_ADDR_A = wr_a;
    assign WR_ADDR_B = wr_b;
    assign WR_EN     = wr_en;
    assign LAYER_IDX = s;
    assign DONE      = done;
    assign SYNC_ERR  = sync_err;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Randomized bench for fft_iter_addr_gen against an arithmetic reference model,
// plus directed checkpoints for the documented address values and boundary cases.
module tb_fft_iter_addr_gen;

    localparam int LAYERS = 5;
    localparam int BF     = 16;

    logic       CLK = 1'b0;
    logic       RST, EN, START, BUT_STROB, ADDR_EN, Wr, LAY_EN, FIRST;
    logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [3:0] TW_ADDR;
    logic [2:0] LAYER_IDX;
    logic       WR_EN, DONE, SYNC_ERR;

    fft_iter_addr_gen #(.LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START), .BUT_STROB(BUT_STROB),
        .ADDR_EN(ADDR_EN), .Wr(Wr), .LAY_EN(LAY_EN), .FIRST(FIRST),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .TW_ADDR(TW_ADDR),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .WR_EN(WR_EN),
        .LAYER_IDX(LAYER_IDX), .DONE(DONE), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    // Reference model state (0 idle, 1 running, 2 finished)
    int m_state, m_s, m_b, m_rd_a, m_rd_b, m_tw, m_wr_a, m_wr_b, m_wr_en, m_done, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int h, pos, grp, na, nb, nt;
        if (RST) begin
            m_state = 0; m_s = 0; m_b = 0; m_rd_a = 0; m_rd_b = 0; m_tw = 0;
            m_wr_a = 0; m_wr_b = 0; m_wr_en = 0; m_done = 0; m_err = 0;
        end else if (EN) begin
            h   = 1 << m_s;
            pos = m_b % h;
            grp = m_b / h;
            na  = grp * 2 * h + pos;
            nb  = na + h;
            nt  = (pos * (1 << (LAYERS - 1 - m_s))) % BF;
            m_wr_en = 0;
            if (START) begin
                m_state = 1; m_s = 0; m_b = 0; m_done = 0; m_err = 0;
            end else if (m_state == 1) begin
                if (BUT_STROB) begin
                    m_wr_a = m_rd_a;
                    m_wr_b = m_rd_b;
                end
                if (ADDR_EN) begin
                    m_wr_en = Wr;
                    if ((int'(LAY_EN) != int'(m_b == BF - 1 && m_s != LAYERS - 1)) ||
                        (int'(FIRST) != int'(m_s == 0)))
                        m_err = 1;
                    m_b = m_b + 1;
                    if (m_b == BF) begin
                        m_b = 0;
                        if (m_s == LAYERS - 1) begin
                            m_done = 1;
                            m_state = 2;
                        end else begin
                            m_s = m_s + 1;
                        end
                    end
                end
            end
            m_rd_a = na; m_rd_b = nb; m_tw = nt;
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        if (WR_EN === 1'b1) pulses++;
        check("rd_a",  RD_ADDR_A, m_rd_a);
        check("rd_b",  RD_ADDR_B, m_rd_b);
        check("tw",    TW_ADDR,   m_tw);
        check("wr_a",  WR_ADDR_A, m_wr_a);
        check("wr_b",  WR_ADDR_B, m_wr_b);
        check("wr_en", WR_EN,     m_wr_en);
        check("layer", LAYER_IDX, m_s);
        check("done",  DONE,      m_done);
        check("err",   SYNC_ERR,  m_err);
    endtask

    task automatic cyc(input logic st, input logic bs, input logic ae, input logic wr,
                       input logic le, input logic fi, input logic en, input logic rst);
        START = st; BUT_STROB = bs; ADDR_EN = ae; Wr = wr;
        LAY_EN = le; FIRST = fi; EN = en; RST = rst;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // One controller butterfly: STROB, gap, write phase, then at least two enabled gap cycles.
    task automatic bfly(input bit inj, input logic wr, input bit rnd, input bit comb);
        logic le, fi;
        int   stall;
        le = (m_b == BF - 1 && m_s != LAYERS - 1);
        fi = (m_s == 0);
        if (inj) le = ~le;
        if (comb) begin
            cyc(0, 1, 1, wr, le, fi, 1, 0);
        end else begin
            cyc(0, 1, 0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0, 0, rnd ? logic'($urandom_range(0, 1)) : 1'b1, 0);
            cyc(0, 0, 1, wr, le, fi, 1, 0);
        end
        stall = rnd ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < stall; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
    endtask

    initial begin
        START = 0; BUT_STROB = 0; ADDR_EN = 0; Wr = 0; LAY_EN = 0; FIRST = 0; EN = 1; RST = 1;
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("rst_rd_b", RD_ADDR_B, 0);
        check("rst_done", DONE, 0);
        check("rst_wr_en", WR_EN, 0);

        // Start of run
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        pulses = 0;
        idle(2);
        check("start_rd_a", RD_ADDR_A, 0);
        check("start_rd_b", RD_ADDR_B, 1);
        check("start_tw", TW_ADDR, 0);
        check("start_layer", LAYER_IDX, 0);
        check("start_done", DONE, 0);

        for (int i = 0; i < 17; i++) bfly(0, 1, 0, 0);
        check("l1b1_layer", LAYER_IDX, 1);
        check("l1b1_rd_a", RD_ADDR_A, 1);
        check("l1b1_rd_b", RD_ADDR_B, 3);
        check("l1b1_tw", TW_ADDR, 8);
        check("l1b1_err", SYNC_ERR, 0);

        for (int i = 0; i < 20; i++) bfly(0, 1, 0, 0);
        check("l2b5_rd_a", RD_ADDR_A, 9);
        check("l2b5_rd_b", RD_ADDR_B, 13);
        check("l2b5_tw", TW_ADDR, 4);

        for (int i = 0; i < 32; i++) bfly(0, 1, 0, 0);
        check("l4b5_layer", LAYER_IDX, 4);
        check("l4b5_rd_a", RD_ADDR_A, 5);
        check("l4b5_rd_b", RD_ADDR_B, 21);
        check("l4b5_tw", TW_ADDR, 5);

        for (int i = 0; i < 10; i++) bfly(0, 1, 0, 0);
        check("pre_done", DONE, 0);
        bfly(0, 1, 0, 0);
        check("done_80", DONE, 1);
        check("pulses_80", pulses, 80);
        check("fin_layer", LAYER_IDX, 4);
        bfly(0, 1, 0, 0);
        check("extra_pulses", pulses, 80);
        check("extra_done", DONE, 1);

        // Misplaced LAY_EN on butterfly 3 of layer 0
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 3; i++) bfly(0, 1, 0, 0);
        check("pre_err", SYNC_ERR, 0);
        bfly(1, 1, 0, 0);
        check("err_set", SYNC_ERR, 1);
        check("err_rd_a", RD_ADDR_A, 8);
        check("err_rd_b", RD_ADDR_B, 9);
        for (int i = 0; i < 2; i++) bfly(0, 1, 0, 0);
        check("err_sticky", SYNC_ERR, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        check("err_clear", SYNC_ERR, 0);

        // Reset mid-run, then START with simultaneous ADDR_EN
        idle(2);
        for (int i = 0; i < 33; i++) bfly(0, 1, 0, 0);
        check("pre_rst_layer", LAYER_IDX, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check("rst_mid_rd_a", RD_ADDR_A, 0);
        check("rst_mid_wr_b", WR_ADDR_B, 0);
        check("rst_mid_layer", LAYER_IDX, 0);
        cyc(1, 0, 1, 1, 0, 1, 1, 0);
        check("st_ae_wr_en", WR_EN, 0);
        idle(2);
        check("st_ae_layer", LAYER_IDX, 0);
        check("st_ae_rd_a", RD_ADDR_A, 0);
        check("st_ae_rd_b", RD_ADDR_B, 1);

        // Randomized runs: stalls, random Wr, combined strobes, rare faults and restarts
        for (int r = 0; r < 6; r++) begin
            int nb;
            cyc(1, 0, 0, 0, 0, 0, 1, 0);
            idle(2);
            nb = int'($urandom_range(20, 90));
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 79) == 0) begin
                    cyc(1, 0, 0, 0, 0, 0, 1, 0);
                    idle(2);
                end
                bfly($urandom_range(0, 39) == 0, logic'($urandom_range(0, 1)), 1,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
